// File: rtl/regfile_pkg.sv
// Shared defaults, address-width derivation and write-port select type for the register file.
package regfile_pkg;

  localparam int unsigned DwDefault   = 16;
  localparam int unsigned NregDefault = 8;

  typedef enum logic [1:0] {
    WselNone,
    WselA,
    WselD
  } wsel_e;

  function automatic int unsigned addr_width(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-load bits: set on load issue, cleared on load-data write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NregDefault,
  parameter int unsigned AW   = addr_width(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] pend
);

  logic [NREG-1:0] pend_q, pend_d;

  // Set is applied after clear so a new issue dominates a same-cycle completion.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (ld_issue) pend_d[ld_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: ALU and load write ports, NRD read ports, load scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW   = DwDefault,
  parameter int unsigned NREG = NregDefault,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = addr_width(NREG)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               we_a,
  input  logic [AW-1:0]      waddr_a,
  input  logic [DW-1:0]      wdata_a,
  input  logic               we_d,
  input  logic [AW-1:0]      waddr_d,
  input  logic [DW-1:0]      wdata_d,
  input  logic               ld_issue,
  input  logic [AW-1:0]      ld_addr,
  input  logic [NRD*AW-1:0]  raddr,
  output logic [NRD*DW-1:0]  rdata,
  output logic [NRD-1:0]     rbusy,
  output logic [NREG-1:0]    pend,
  output logic [NREG*DW-1:0] dbg_q,
  output logic [15:0]        wcnt
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];
  wsel_e         wsel  [NREG];
  logic [15:0]   wcnt_q;
  logic [1:0]    nwr;

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .clr_en   (we_d),
    .clr_addr (waddr_d),
    .pend     (pend)
  );

  // Port A is evaluated last so it wins a same-address collision.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wsel[r] = WselNone;
      if (we_d && (waddr_d == AW'(r))) wsel[r] = WselD;
      if (we_a && (waddr_a == AW'(r))) wsel[r] = WselA;
      case (wsel[r])
        WselA:   mem_d[r] = wdata_a;
        WselD:   mem_d[r] = wdata_d;
        default: mem_d[r] = mem_q[r];
      endcase
    end
  end

  assign nwr = {1'b0, we_a} + {1'b0, we_d && !(we_a && (waddr_a == waddr_d))};

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
      wcnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= mem_d[r];
      wcnt_q <= wcnt_q + 16'(nwr);
    end
  end

  assign wcnt = wcnt_q;

  always_comb begin
    logic [AW-1:0] ra;
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      rdata[i*DW +: DW] = mem_q[ra];
      rbusy[i]          = pend[ra];
`ifdef REGFILE_BYPASS_EN
      if (we_d && (waddr_d == ra)) begin
        rdata[i*DW +: DW] = wdata_d;
        if (!(ld_issue && (ld_addr == ra))) rbusy[i] = 1'b0;
      end
      if (we_a && (waddr_a == ra)) rdata[i*DW +: DW] = wdata_a;
`endif
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) dbg_q[r*DW +: DW] = mem_q[r];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model plus a read scoreboard queue.
module tb_regfile_mp;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int NRD  = 2;
  localparam int AW   = 3;

  logic               CLK = 1'b0;
  logic               RST;
  logic               we_a, we_d, ld_issue;
  logic [AW-1:0]      waddr_a, waddr_d, ld_addr;
  logic [DW-1:0]      wdata_a, wdata_d;
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata;
  logic [NRD-1:0]     rbusy;
  logic [NREG-1:0]    pend;
  logic [NREG*DW-1:0] dbg_q;
  logic [15:0]        wcnt;

  regfile_mp #(
    .DW   (DW),
    .NREG (NREG),
    .NRD  (NRD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .we_a     (we_a),
    .waddr_a  (waddr_a),
    .wdata_a  (wdata_a),
    .we_d     (we_d),
    .waddr_d  (waddr_d),
    .wdata_d  (wdata_d),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .pend     (pend),
    .dbg_q    (dbg_q),
    .wcnt     (wcnt)
  );

  always #5 CLK = ~CLK;

  int n_err = 0;
  int n_chk = 0;

  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_pend;
  logic [15:0]     m_cnt;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];
  int            port_q [$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f = '0;
    for (int r = 0; r < NREG; r++) f[r*DW +: DW] = m_mem[r];
    return f;
  endfunction

  // Advance the model with the currently driven inputs, clock once, then drop enables.
  task automatic tick();
    if (RST) begin
      for (int r = 0; r < NREG; r++) m_mem[r] = '0;
      m_pend = '0;
      m_cnt  = '0;
    end else begin
      if (we_d) m_mem[waddr_d] = wdata_d;
      if (we_a) m_mem[waddr_a] = wdata_a;
      if (we_d) m_pend[waddr_d] = 1'b0;
      if (ld_issue) m_pend[ld_addr] = 1'b1;
      m_cnt = m_cnt + 16'(we_a) + 16'(we_d && !(we_a && waddr_a == waddr_d));
    end
    @(posedge CLK);
    #1;
    we_a = 0; we_d = 0; ld_issue = 0;
    waddr_a = 'x; waddr_d = 'x; wdata_a = 'x; wdata_d = 'x; ld_addr = 'x;
  endtask

  // Drive a read address, push the model's expectation, then compare once settled.
  task automatic rd(input int p, input int a, input string tag);
    raddr[p*AW +: AW] = AW'(a);
    exp_q.push_back(m_mem[a]);
    tag_q.push_back(tag);
    port_q.push_back(p);
    #1;
    while (exp_q.size() > 0) begin
      automatic logic [DW-1:0] e = exp_q.pop_front();
      automatic string t = tag_q.pop_front();
      automatic int pp = port_q.pop_front();
      check_val(t, rdata[pp*DW +: DW], e);
    end
    check_val({tag, "_busy"}, rbusy[p], m_pend[a]);
  endtask

  initial begin
    RST = 1; we_a = 0; we_d = 0; ld_issue = 0;
    waddr_a = '0; waddr_d = '0; wdata_a = '0; wdata_d = '0; ld_addr = '0; raddr = '0;
    #1;
    tick();
    tick();
    RST = 0;
    check_val("rst_pend", pend, 0);
    check_val("rst_wcnt", wcnt, 0);
    check_val("rst_dbg", dbg_q, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_rbusy", rbusy, 0);

    we_a = 1; waddr_a = 3; wdata_a = 16'h1234;
    tick();
    rd(0, 3, "r3_rd");
    check_val("r3_rd_const", rdata[DW-1:0], 16'h1234);
    check_val("wcnt_1", wcnt, 16'd1);

    we_a = 1; waddr_a = 5; wdata_a = 16'hAAAA;
    we_d = 1; waddr_d = 5; wdata_d = 16'h5555;
    tick();
    rd(1, 5, "r5_collide");
    check_val("r5_collide_const", rdata[2*DW-1:DW], 16'hAAAA);
    check_val("wcnt_collide", wcnt, m_cnt);

    we_a = 1; waddr_a = 1; wdata_a = 16'hC001;
    we_d = 1; waddr_d = 2; wdata_d = 16'hD002;
    tick();
    rd(0, 1, "r1_dual");
    rd(1, 2, "r2_dual");
    check_val("wcnt_dual", wcnt, 16'd4);
    check_val("dbg_dual", dbg_q, m_flat());

    ld_issue = 1; ld_addr = 4;
    tick();
    check_val("pend_ld4", pend, 8'h10);
    rd(0, 4, "r4_pend");
    check_val("rbusy_ld4", rbusy[0], 1'b1);
    we_a = 1; waddr_a = 4; wdata_a = 16'h7777;
    tick();
    check_val("pend_we_a", pend, 8'h10);
    we_d = 1; waddr_d = 4; wdata_d = 16'h0BEE;
    tick();
    check_val("pend_clr", pend, 8'h00);
    rd(0, 4, "r4_load");
    ld_issue = 1; ld_addr = 4; we_d = 1; waddr_d = 4; wdata_d = 16'h1BEE;
    tick();
    check_val("pend_issue_dom", pend[4], 1'b1);
    rd(1, 4, "r4_reissue");

    we_a = 1; waddr_a = 6; wdata_a = 16'h1111;
    tick();
    raddr[AW +: AW] = 3'd6;
    we_a = 1; waddr_a = 6; wdata_a = 16'h00FF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("bypass_r6", rdata[2*DW-1:DW], 16'h00FF);
`else
    check_val("nobypass_r6", rdata[2*DW-1:DW], 16'h1111);
`endif
    tick();
    rd(1, 6, "r6_after");
    check_val("r6_after_const", rdata[2*DW-1:DW], 16'h00FF);

    ld_issue = 1; ld_addr = 3;
    tick();
    RST = 1; we_a = 1; waddr_a = 7; wdata_a = 16'hFFFF; ld_issue = 1; ld_addr = 2;
    tick();
    RST = 0;
    check_val("rst_ovr_dbg", dbg_q, 0);
    check_val("rst_ovr_pend", pend, 0);
    check_val("rst_ovr_wcnt", wcnt, 0);
    rd(0, 7, "rst_ovr_r7");
    we_d = 1; waddr_d = 3; wdata_d = 16'h3333;
    tick();
    rd(0, 3, "late_ld");

    RST = 1;
    tick();
    RST = 0;
    for (int k = 0; k < 32767; k++) begin
      we_a = 1; waddr_a = 0; wdata_a = 16'(k);
      we_d = 1; waddr_d = 1; wdata_d = 16'(~k);
      tick();
    end
    we_a = 1; waddr_a = 2; wdata_a = 16'h0002;
    tick();
    check_val("wcnt_ffff", wcnt, 16'hFFFF);
    we_d = 1; waddr_d = 3; wdata_d = 16'h0003;
    tick();
    check_val("wcnt_wrap", wcnt, 16'h0000);
    check_val("wcnt_model", wcnt, m_cnt);
    check_val("dbg_final", dbg_q, m_flat());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DW, default 16, register data width.
REQ-002 SHALL have parameter NREG, default 8, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have ports: CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: we_a  in  1 / waddr_a  in  AW / wdata_a  in  DW  ALU-result write port (ADD/LI/MUL).
REQ-007 SHALL have ports: we_d  in  1 / waddr_d  in  AW / wdata_d  in  DW  load-data write port (LD completion).
REQ-008 SHALL have ports: ld_issue  in  1 / ld_addr  in  AW  load issued; marks destination pending.
REQ-009 SHALL have ports: raddr  in  NRD*AW / rdata  out  NRD*DW  read ports, port i in slice i.
REQ-010 SHALL have ports: rbusy  out  NRD  port i address has a pending load.
REQ-011 SHALL have ports: pend  out  NREG  scoreboard bit per register.
REQ-012 SHALL have ports: dbg_q  out  NREG*DW  all registers flattened, register 0 in LSBs.
REQ-013 SHALL have ports: wcnt  out  16  count of committed register writes.

Function
REQ-014 SHALL update register waddr_a with wdata_a at edge when we_a=1.
REQ-015 SHALL update register waddr_d with wdata_d at edge when we_d=1.
REQ-016 SHALL, on we_a and we_d to same address same cycle, store wdata_a (port A wins); the count still increments by 1.
REQ-017 SHALL, on we_a and we_d to different addresses, perform both writes in one cycle.
REQ-018 SHALL drive rdata combinationally from raddr with zero-cycle latency; reading is side-effect free.
REQ-019 SHALL set pend[ld_addr] at edge when ld_issue=1.
REQ-020 SHALL clear pend[waddr_d] at edge when we_d=1.
REQ-021 SHALL, on ld_issue and we_d to same address same cycle, leave pend set (new issue dominates).
REQ-022 SHALL NOT change pend on we_a writes.
REQ-023 SHALL drive rbusy[i] = pend[raddr slice i] combinationally.
REQ-024 SHALL increment wcnt by number of distinct committed addresses (0, 1 or 2) per cycle, wrapping 0xFFFF->0x0000.
REQ-025 SHALL treat wdata/waddr as don't-care when the corresponding enable is 0.

Reset
REQ-026 SHALL, while RST=1 at an edge, clear all registers, pend, and wcnt to 0, overriding any concurrent write or ld_issue.
REQ-027 SHALL drive rdata, rbusy, dbg_q to 0 in the cycle following reset (bypass excepted, REQ-029).
REQ-028 SHALL resume normal operation on the first edge with RST=0; in-flight loads at reset are forgotten, a later we_d still writes.

Configuration
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to rdata when raddr matches an enabled write address (port A priority over D), and clear rbusy for a port whose address matches a same-cycle we_d without a same-address ld_issue.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return only stored values; new data visible the cycle after the write.

Structure
REQ-031 SHALL place DW/NREG defaults, AW derivation, and a write-port-select enum (NONE, A, D) in shared package regfile_pkg.
REQ-032 SHALL implement the per-register scoreboard as sub-module regfile_scoreboard (set/clear/priority, outputs pend).
REQ-033 SHALL keep storage, write arbitration, read muxing and bypass in regfile_mp.

Verification
REQ-034 SHALL cover: reset, we_a r3<=0x1234, next cycle raddr0=3 -> rdata0=0x1234, wcnt=1.
REQ-035 SHALL cover: we_a r5<=0xAAAA and we_d r5<=0x5555 same cycle -> r5=0xAAAA, wcnt+1; different addresses r1/r2 -> both written, wcnt+2.
REQ-036 SHALL cover: ld_issue r4 -> pend=0x10, rbusy for raddr=4; we_d r4<=0x0BEE -> pend=0, r4=0x0BEE; ld_issue r4 with we_d r4 same cycle -> pend[4] stays 1.
REQ-037 SHALL cover: REGFILE_BYPASS_EN on, we_a r6<=0x00FF with raddr1=6 same cycle -> rdata1=0x00FF; off -> rdata1 old value, 0x00FF next cycle.
REQ-038 SHALL cover: RST asserted with we_a r7<=0xFFFF and ld_issue r2 -> r7=0, pend=0, wcnt=0; wcnt wrap from 0xFFFF via one write -> 0x0000.
